// File: rtl/i2s_rx_pkg.sv
// -----------------------------------------------------------------------------
// i2s_rx_pkg
// Shared types and default constants for the I2S receive frame controller.
//   state_e   : controller FSM states (IDLE, ARM, WAIT_R, WAIT_L)
//   frame_t   : packed stereo frame {left, right} at the default word width
//   *_DEF     : default values for the controller parameters
// -----------------------------------------------------------------------------
package i2s_rx_pkg;

    localparam int DATA_WIDTH_DEF  = 24;
    localparam int FIFO_DEPTH_DEF  = 4;
    localparam int TIMEOUT_CYC_DEF = 128;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARM    = 2'd1,
        WAIT_R = 2'd2,
        WAIT_L = 2'd3
    } state_e;

    typedef struct packed {
        logic [DATA_WIDTH_DEF-1:0] left;
        logic [DATA_WIDTH_DEF-1:0] right;
    } frame_t;

endpackage

// File: rtl/i2s_rx_frame_ctrl_fifo.sv
// -----------------------------------------------------------------------------
// i2s_frame_fifo
// Synchronous first-word-fall-through FIFO holding stereo frames.
//   clk, rst   : clock, asynchronous active-high reset (flushes contents)
//   push_i     : write data_i (accepted when not full, or full with a pop)
//   data_i     : frame to write
//   pop_i      : remove the head entry (ignored when empty)
//   data_o     : head entry, valid whenever empty_o is low
//   full_o     : all DEPTH entries occupied
//   empty_o    : no entries
//   level_o    : current occupancy, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module i2s_frame_fifo #(
    parameter int WIDTH = 48,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           data_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] level_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == LW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign level_o = count_q;
    // Head is read combinationally so a frame written at cycle N shows at N+1.
    assign data_o  = mem_q[rd_ptr_q];

    assign do_pop  = pop_i && !empty_o;
    // A full FIFO can still take a frame when the head leaves in the same cycle.
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + LW'(1);
            2'b01:   count_d = count_q - LW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is cleared on reset so the head output reads 0 out of reset.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_slot
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    mem_q[gi] <= '0;
                end else if (do_push && (wr_ptr_q == AW'(gi))) begin
                    mem_q[gi] <= data_i;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/i2s_rx_frame_ctrl.sv
// -----------------------------------------------------------------------------
// i2s_rx_frame_ctrl
// Sequences the I2S receive decoder and pairs its left/right words into
// stereo frames, buffered in a small FWFT FIFO with a valid/ready output.
//   clk, rst                     : clock, asynchronous active-high reset
//   start_i / stop_i             : begin capture / end after current frame
//   dec_en_o                     : registered decoder enable
//   left_*_i / right_*_i         : decoder words and their strobes
//   frame_valid_o/frame_ready_i  : downstream handshake
//   frame_left_o/frame_right_o   : head frame
//   fifo_level_o                 : FIFO occupancy
//   busy_o                       : controller not in IDLE
//   overflow_o / sync_err_o      : sticky error flags, cleared by clr_err_i
//   err_cnt_o                    : only with I2S_RX_ERR_CNT_EN defined;
//                                  saturating count of sync errors + drops
// -----------------------------------------------------------------------------
module i2s_rx_frame_ctrl
    import i2s_rx_pkg::*;
#(
    parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int FIFO_DEPTH  = FIFO_DEPTH_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start_i,
    input  logic                            stop_i,
    output logic                            dec_en_o,
    input  logic [DATA_WIDTH-1:0]           left_word_i,
    input  logic                            left_valid_i,
    input  logic [DATA_WIDTH-1:0]           right_word_i,
    input  logic                            right_valid_i,
    output logic                            frame_valid_o,
    input  logic                            frame_ready_i,
    output logic [DATA_WIDTH-1:0]           frame_left_o,
    output logic [DATA_WIDTH-1:0]           frame_right_o,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level_o,
    output logic                            busy_o,
    output logic                            overflow_o,
    output logic                            sync_err_o,
    input  logic                            clr_err_i
`ifdef I2S_RX_ERR_CNT_EN
    ,
    output logic [7:0]                      err_cnt_o
`endif
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    state_e                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   left_q, left_d;
    logic [TW-1:0]           tmo_q, tmo_d;
    logic                    stop_pend_q, stop_pend_d;
    logic                    dec_en_q, dec_en_d;
    logic                    overflow_q, overflow_d;
    logic                    sync_err_q, sync_err_d;

    logic                    push;
    logic                    pop;
    logic                    drop;
    logic                    sync_evt;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    both_valid;
    logic                    tmo_hit;
    logic                    leave_pend;
    logic [2*DATA_WIDTH-1:0] head;

    assign both_valid = left_valid_i && right_valid_i;
    assign tmo_hit    = (tmo_q == TW'(TIMEOUT_CYC));
    // A stop raised this cycle counts as pending for the pair completing now.
    assign leave_pend = stop_pend_q || stop_i;

    always_comb begin
        state_d     = state_q;
        left_d      = left_q;
        tmo_d       = tmo_q;
        stop_pend_d = stop_pend_q;
        push        = 1'b0;
        sync_evt    = 1'b0;
        case (state_q)
            IDLE: begin
                stop_pend_d = 1'b0;
                tmo_d       = '0;
                if (start_i && !stop_i) begin
                    state_d = ARM;
                end
            end
            ARM: begin
                tmo_d = '0;
                if (stop_i) begin
                    state_d = IDLE;
                end else if (both_valid) begin
                    sync_evt = 1'b1;
                end else if (left_valid_i) begin
                    left_d  = left_word_i;
                    state_d = WAIT_R;
                end
                // A lone right word here is the tail of a pair we never saw.
            end
            WAIT_R: begin
                tmo_d = tmo_q + TW'(1);
                if (stop_i) begin
                    stop_pend_d = 1'b1;
                end
                if (both_valid) begin
                    sync_evt = 1'b1;
                    tmo_d    = '0;
                    state_d  = leave_pend ? IDLE : ARM;
                end else if (right_valid_i) begin
                    push    = 1'b1;
                    tmo_d   = '0;
                    state_d = leave_pend ? IDLE : WAIT_L;
                end else if (left_valid_i) begin
                    // Two lefts in a row: keep the newest one.
                    sync_evt = 1'b1;
                    left_d   = left_word_i;
                    tmo_d    = '0;
                end else if (tmo_hit) begin
                    sync_evt = 1'b1;
                    tmo_d    = '0;
                    state_d  = leave_pend ? IDLE : ARM;
                end
            end
            WAIT_L: begin
                tmo_d = tmo_q + TW'(1);
                if (stop_i) begin
                    state_d = IDLE;
                end else if (both_valid) begin
                    sync_evt = 1'b1;
                    tmo_d    = '0;
                    state_d  = ARM;
                end else if (left_valid_i) begin
                    left_d  = left_word_i;
                    tmo_d   = '0;
                    state_d = WAIT_R;
                end else if (right_valid_i) begin
                    sync_evt = 1'b1;
                end else if (tmo_hit) begin
                    sync_evt = 1'b1;
                    tmo_d    = '0;
                    state_d  = ARM;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Enable follows the next state so it rises after start and drops on
    // the same edge that enters IDLE.
    assign dec_en_d = (state_d != IDLE);

    assign pop  = frame_valid_o && frame_ready_i;
    assign drop = push && fifo_full && !pop;

    // New errors take priority over a simultaneous clear.
    assign overflow_d = (overflow_q && !clr_err_i) || drop;
    assign sync_err_d = (sync_err_q && !clr_err_i) || sync_evt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            left_q      <= '0;
            tmo_q       <= '0;
            stop_pend_q <= 1'b0;
            dec_en_q    <= 1'b0;
            overflow_q  <= 1'b0;
            sync_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            left_q      <= left_d;
            tmo_q       <= tmo_d;
            stop_pend_q <= stop_pend_d;
            dec_en_q    <= dec_en_d;
            overflow_q  <= overflow_d;
            sync_err_q  <= sync_err_d;
        end
    end

`ifdef I2S_RX_ERR_CNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;
    logic [7:0] cnt_base;
    logic [8:0] cnt_sum;

    always_comb begin
        cnt_base  = clr_err_i ? 8'd0 : err_cnt_q;
        cnt_sum   = {1'b0, cnt_base} + 9'(sync_evt) + 9'(drop);
        err_cnt_d = cnt_sum[8] ? 8'hFF : cnt_sum[7:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt_q <= 8'd0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt_o = err_cnt_q;
`endif

    i2s_frame_fifo #(
        .WIDTH (2 * DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .data_i  ({left_q, right_word_i}),
        .pop_i   (pop),
        .data_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level_o)
    );

    assign frame_valid_o = !fifo_empty;
    assign frame_left_o  = head[2*DATA_WIDTH-1:DATA_WIDTH];
    assign frame_right_o = head[DATA_WIDTH-1:0];
    assign dec_en_o      = dec_en_q;
    assign busy_o        = (state_q != IDLE);
    assign overflow_o    = overflow_q;
    assign sync_err_o    = sync_err_q;

endmodule

// File: doc/i2s_rx_frame_ctrl.md
Name: i2s_rx_frame_ctrl

Overview:
- Controller that sequences the I2S receive decoder and pairs its outputs into stereo frames.
- Drives the decoder enable and accepts the decoder's left/right word-valid pulses.
- Pairs each left word with the following right word and buffers the frames in a small FIFO.
- Presents frames downstream on a valid/ready interface, with sticky overflow and channel-sync error flags.

Parameters:
- DATA_WIDTH, 24, width of one audio word; must match the decoder.
- FIFO_DEPTH, 4, number of stereo frames buffered; power of two, ≥2.
- TIMEOUT_CYC, 128, clk cycles allowed between the words of a pair before a sync error.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- start_i  in  1  pulse: begin capture.
- stop_i  in  1  pulse: end capture after the current frame.
- dec_en_o  out  1  enable to the decoder.
- left_word_i  in  DATA_WIDTH  decoder left word.
- left_valid_i  in  1  decoder left-word strobe.
- right_word_i  in  DATA_WIDTH  decoder right word.
- right_valid_i  in  1  decoder right-word strobe.
- frame_valid_o  out  1  FIFO head holds a frame.
- frame_ready_i  in  1  downstream accepts the frame.
- frame_left_o  out  DATA_WIDTH  left word of the head frame.
- frame_right_o  out  DATA_WIDTH  right word of the head frame.
- fifo_level_o  out  $clog2(FIFO_DEPTH+1)  current FIFO occupancy.
- busy_o  out  1  state is not IDLE.
- overflow_o  out  1  sticky: a frame was dropped because the FIFO was full.
- sync_err_o  out  1  sticky: channel order was violated or a pair timed out.
- clr_err_i  in  1  clears the sticky flags (and the counter, if built).

Behaviour:
- Reset: all outputs 0, FIFO empty, state IDLE, timeout counter 0, stop_pend 0.
- IDLE: dec_en_o=0.
  - start_i → ARM; dec_en_o rises the cycle after start_i (registered).
  - start_i and stop_i in the same cycle: stop wins, stay IDLE.
- ARM: right_valid_i is ignored (no error).
  - left_valid_i → capture left word, go to WAIT_R.
- WAIT_R:
  - right_valid_i → push {held left, right_word_i}; go to WAIT_L, or to IDLE if stop_pend is set.
  - left_valid_i → sync_err_o=1, replace the held left word, stay in WAIT_R.
- WAIT_L:
  - left_valid_i → capture left word, go to WAIT_R.
  - right_valid_i → sync_err_o=1, discard the word.
- Simultaneous left_valid_i and right_valid_i: treat as sync error, discard both, go to ARM.
- Timeout counter:
  - Width $clog2(TIMEOUT_CYC+1); runs in WAIT_R and WAIT_L.
  - Clears on every accepted word.
  - Reaching TIMEOUT_CYC → sync_err_o=1, go to ARM (or to IDLE if stop_pend is set); the held left word is discarded.
- stop_i:
  - In ARM/WAIT_L → IDLE next cycle.
  - In WAIT_R → set stop_pend; leave after the right word or a timeout.
  - dec_en_o falls on entry to IDLE; stop_pend clears in IDLE.
- FIFO:
  - First-word fall-through; frame_valid_o = !empty.
  - A frame pushed at cycle N is visible at N+1 if the FIFO was empty.
  - Pop when frame_valid_o && frame_ready_i.
  - Head data is held stable while valid && !ready.
  - Push when full with no pop that cycle → frame dropped, overflow_o=1.
  - Push when full with a simultaneous pop → accepted; level is unchanged.
  - FIFO contents survive stop; they are flushed only by rst.
- Sticky flags:
  - clr_err_i clears both flags.
  - If a new error occurs in the same cycle as clr_err_i, the error wins and the flag reads 1.
- Async rst mid-frame: immediate IDLE, partial pair lost, dec_en_o=0.

Optional Feature:
- Macro: I2S_RX_ERR_CNT_EN.
- Defined: adds port err_cnt_o (out, 8 bits).
  - Saturating count of sync errors plus dropped frames.
  - An overflow and a sync error in the same cycle add 2.
  - Cleared by clr_err_i or rst.
- Undefined: port and counter are absent; everything else is identical.

Decomposition:
- Package i2s_rx_pkg holds:
  - state enum {IDLE, ARM, WAIT_R, WAIT_L};
  - packed frame struct typedef {left, right}, parameterised by DATA_WIDTH via a package localparam default of 24;
  - default constants for FIFO_DEPTH and TIMEOUT_CYC.
- One sub-module: i2s_frame_fifo, a synchronous FWFT FIFO with push, pop, full, empty and level.

Test Plan:
- start, L=0x123456 then R=0xABCDEF, ready=1 → one cycle after the R strobe, frame_valid_o=1 with left=0x123456, right=0xABCDEF; level returns to 0.
- ready=0, feed 5 pairs with FIFO_DEPTH=4 → level=4, overflow_o=1, fifth frame absent; draining returns frames 1–4 in order.
- L, L(0x000001), R(0x000002) → sync_err_o=1; the frame pushed is {0x000001, 0x000002}. Then clr_err_i → flag 0.
- L, then no R for 128 cycles → sync_err_o=1, state ARM, no frame pushed; a following R-only strobe is ignored without error.
- stop_i asserted in WAIT_R, R arrives 10 cycles later → frame pushed, dec_en_o falls the next cycle, busy_o=0.
- Async rst pulsed while in WAIT_R with 2 frames queued → all outputs 0 immediately, level 0. With I2S_RX_ERR_CNT_EN defined, err_cnt_o=0.
